// File: rtl/axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_arbiter
// Purpose  : Round-robin sharing of one AXI4-Lite slave port among MASTERS
//            requesters, one transaction in flight. Optional macro
//            ARB_TIMEOUT_EN adds a per-transaction watchdog (SLVERR reply).
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master_arbiter #(
  parameter int MASTERS = 2,
  parameter int SWORD   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [MASTERS-1:0]           M_AWVALID,
  input  logic [MASTERS-1:0]           M_WVALID,
  input  logic [MASTERS-1:0]           M_ARVALID,
  input  logic [MASTERS-1:0]           M_BREADY,
  input  logic [MASTERS-1:0]           M_RREADY,
  input  logic [MASTERS*SWORD-1:0]     M_AWADDR,
  input  logic [MASTERS*SWORD-1:0]     M_ARADDR,
  input  logic [MASTERS*SWORD-1:0]     M_WDATA,
  input  logic [MASTERS*SWORD/8-1:0]   M_WSTRB,
  output logic [MASTERS-1:0]           M_AWREADY,
  output logic [MASTERS-1:0]           M_WREADY,
  output logic [MASTERS-1:0]           M_ARREADY,
  output logic [MASTERS-1:0]           M_BVALID,
  output logic [MASTERS-1:0]           M_RVALID,
  output logic [2*MASTERS-1:0]         M_BRESP,
  output logic [2*MASTERS-1:0]         M_RRESP,
  output logic [MASTERS*SWORD-1:0]     M_RDATA,
  output logic                         S_AWVALID,
  output logic                         S_WVALID,
  output logic                         S_ARVALID,
  output logic                         S_BREADY,
  output logic                         S_RREADY,
  output logic [SWORD-1:0]             S_AWADDR,
  output logic [SWORD-1:0]             S_ARADDR,
  output logic [SWORD-1:0]             S_WDATA,
  output logic [SWORD/8-1:0]           S_WSTRB,
  input  logic                         S_AWREADY,
  input  logic                         S_WREADY,
  input  logic                         S_ARREADY,
  input  logic                         S_BVALID,
  input  logic                         S_RVALID,
  input  logic [1:0]                   S_BRESP,
  input  logic [1:0]                   S_RRESP,
  input  logic [SWORD-1:0]             S_RDATA,
  output logic [MASTERS-1:0]           GRANT,
  output logic                         BUSY
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SB = SWORD / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic [MASTERS-1:0] r_grant, w_req;
  logic [IW-1:0]      r_gidx, r_ptr, w_pick, w_idx;
  logic               r_aw_done, r_w_done, r_ar_done;
  logic               w_found, w_aw_hs, w_w_hs, w_ar_hs, w_done, w_to;

  generate
    if (MASTERS < 2 || MASTERS > 8 || (SWORD % 8) != 0 || TIMEOUT < 1) begin : g_param_check
      $error("axi_lite_master_arbiter: unsupported parameter set");
    end
  endgenerate

  assign w_req = (M_AWVALID & M_WVALID) | M_ARVALID;
  assign GRANT = r_grant;
  assign BUSY  = (r_state != ST_IDLE);

  // Round-robin scan starting just after the last owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % MASTERS);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_next = (M_AWVALID[w_pick] && M_WVALID[w_pick]) ? ST_WRITE : ST_READ;
      ST_WRITE,
      ST_READ:  if (w_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= IW'(MASTERS - 1);
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_found) begin
        r_grant <= MASTERS'(1) << w_pick;
        r_gidx  <= w_pick;
      end
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else if (w_done) begin
      r_ptr     <= r_gidx;
      r_grant   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_ar_hs) r_ar_done <= 1'b1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                         r_cnt <= '0;
    else if (r_state == ST_IDLE)      r_cnt <= '0;
    else if (r_cnt != CW'(TIMEOUT))   r_cnt <= r_cnt + CW'(1);
  end

  assign w_to = (r_state != ST_IDLE) && (r_cnt == CW'(TIMEOUT));
`else
  assign w_to = 1'b0;
`endif

  // Channel routing: only the granted master ever sees a ready/valid.
  always_comb begin
    M_AWREADY = '0;
    M_WREADY  = '0;
    M_ARREADY = '0;
    M_BVALID  = '0;
    M_RVALID  = '0;
    M_BRESP   = '0;
    M_RRESP   = '0;
    M_RDATA   = '0;
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    S_ARVALID = 1'b0;
    S_BREADY  = 1'b0;
    S_RREADY  = 1'b0;
    S_AWADDR  = '0;
    S_ARADDR  = '0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    w_aw_hs   = 1'b0;
    w_w_hs    = 1'b0;
    w_ar_hs   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      ST_WRITE: begin
        S_AWADDR = M_AWADDR[r_gidx*SWORD +: SWORD];
        S_WDATA  = M_WDATA[r_gidx*SWORD +: SWORD];
        S_WSTRB  = M_WSTRB[r_gidx*SB +: SB];
        if (w_to) begin
          M_AWREADY[r_gidx]          = ~r_aw_done;
          M_WREADY[r_gidx]           = ~r_w_done;
          M_BVALID[r_gidx]           = 1'b1;
          M_BRESP[r_gidx*2 +: 2]     = 2'b10;
          w_done                     = M_BREADY[r_gidx];
        end else begin
          S_AWVALID         = M_AWVALID[r_gidx] & ~r_aw_done;
          S_WVALID          = M_WVALID[r_gidx] & ~r_w_done;
          M_AWREADY[r_gidx] = S_AWREADY & ~r_aw_done;
          M_WREADY[r_gidx]  = S_WREADY & ~r_w_done;
          w_aw_hs           = S_AWVALID & S_AWREADY;
          w_w_hs            = S_WVALID & S_WREADY;
          if (r_aw_done && r_w_done) begin
            M_BVALID[r_gidx]       = S_BVALID;
            M_BRESP[r_gidx*2 +: 2] = S_BRESP;
            S_BREADY               = M_BREADY[r_gidx];
            w_done                 = S_BVALID & M_BREADY[r_gidx];
          end
        end
      end
      ST_READ: begin
        S_ARADDR = M_ARADDR[r_gidx*SWORD +: SWORD];
        if (w_to) begin
          M_ARREADY[r_gidx]      = ~r_ar_done;
          M_RVALID[r_gidx]       = 1'b1;
          M_RRESP[r_gidx*2 +: 2] = 2'b10;
          w_done                 = M_RREADY[r_gidx];
        end else begin
          S_ARVALID         = M_ARVALID[r_gidx] & ~r_ar_done;
          M_ARREADY[r_gidx] = S_ARREADY & ~r_ar_done;
          w_ar_hs           = S_ARVALID & S_ARREADY;
          if (r_ar_done) begin
            M_RVALID[r_gidx]               = S_RVALID;
            M_RRESP[r_gidx*2 +: 2]         = S_RRESP;
            M_RDATA[r_gidx*SWORD +: SWORD] = S_RDATA;
            S_RREADY                       = M_RREADY[r_gidx];
            w_done                         = S_RVALID & M_RREADY[r_gidx];
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master_arbiter
// Purpose  : Directed scoreboard bench for axi_lite_master_arbiter (2 masters);
//            the SLVERR watchdog step runs when ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_arbiter;

  localparam int MASTERS = 2;
  localparam int SWORD   = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]  m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic [63:0] m_awaddr, m_araddr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID;
  logic [3:0]  M_BRESP, M_RRESP;
  logic [63:0] M_RDATA;
  logic        S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY;
  logic [31:0] S_AWADDR, S_ARADDR, S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [1:0]  GRANT;
  logic        BUSY;

  axi_lite_master_arbiter #(.MASTERS(MASTERS), .SWORD(SWORD), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .M_AWVALID(m_awvalid), .M_WVALID(m_wvalid), .M_ARVALID(m_arvalid),
    .M_BREADY(m_bready), .M_RREADY(m_rready),
    .M_AWADDR(m_awaddr), .M_ARADDR(m_araddr), .M_WDATA(m_wdata), .M_WSTRB(m_wstrb),
    .M_AWREADY(M_AWREADY), .M_WREADY(M_WREADY), .M_ARREADY(M_ARREADY),
    .M_BVALID(M_BVALID), .M_RVALID(M_RVALID),
    .M_BRESP(M_BRESP), .M_RRESP(M_RRESP), .M_RDATA(M_RDATA),
    .S_AWVALID(S_AWVALID), .S_WVALID(S_WVALID), .S_ARVALID(S_ARVALID),
    .S_BREADY(S_BREADY), .S_RREADY(S_RREADY),
    .S_AWADDR(S_AWADDR), .S_ARADDR(S_ARADDR), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
    .S_AWREADY(s_awready), .S_WREADY(s_wready), .S_ARREADY(s_arready),
    .S_BVALID(s_bvalid), .S_RVALID(s_rvalid),
    .S_BRESP(s_bresp), .S_RRESP(s_rresp), .S_RDATA(s_rdata),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  int n_checks = 0;
  int n_errors = 0;
  int aw_hs = 0;
  int w_hs  = 0;
  logic [63:0] sb[$];

  // Slave-side handshake counters.
  always @(posedge CLK) begin
    if (S_AWVALID && s_awready) aw_hs <= aw_hs + 1;
    if (S_WVALID && s_wready)   w_hs  <= w_hs + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed %0h expected <none queued>", tag, obs);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '0; m_rready = '0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
    s_bresp = '0; s_rresp = '0; s_rdata = '0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    clear_inputs();
    repeat (2) cyc();
    RST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int hs_aw0, hs_w0;

  initial begin
    // ---- Reset state
    clear_inputs();
    repeat (2) cyc();
    #1;
    chk("rst_grant_busy", {GRANT, BUSY}, 3'b000);
    chk("rst_s_valids", {S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY}, 5'b0);
    chk("rst_m_side", {M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID}, 10'b0);
    chk("rst_m_data", M_RDATA, 64'h0);
    RST = 1'b1;

    // ---- T1: master0 write 0x400 / 0xABC
    cyc();
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
    m_awaddr = 64'h400; m_wdata = 64'hABC; m_wstrb = 8'h0F;
    sb.push_back(64'h400); sb.push_back(64'hABC);
    #1;
    chk("t1_pre_grant", {GRANT, S_AWVALID}, 3'b000);
    cyc(); #1;
    chk("t1_grant", {GRANT, BUSY}, 3'b011);
    chk("t1_s_valids", {S_AWVALID, S_WVALID}, 2'b11);
    chk_sb("t1_awaddr", S_AWADDR);
    chk_sb("t1_wdata", S_WDATA);
    chk("t1_wstrb", S_WSTRB, 4'hF);
    s_awready = 1'b1; s_wready = 1'b1; #1;
    chk("t1_m_ready", {M_AWREADY, M_WREADY}, 4'b0101);
    cyc();
    m_awvalid = '0; m_wvalid = '0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; #1;
    chk("t1_bvalid", {M_BVALID, M_BRESP, S_BREADY}, {2'b01, 4'b0000, 1'b1});
    chk("t1_s_valids_done", {S_AWVALID, S_WVALID}, 2'b00);
    cyc(); s_bvalid = 1'b0; #1;
    chk("t1_grant_clear", {GRANT, BUSY}, 3'b000);

    // ---- T2: simultaneous reads, master0 then master1
    do_reset();
    cyc();
    m_arvalid = 2'b11; m_araddr = {32'h408, 32'h408}; m_rready = 2'b11; #1;
    chk("t2_pre_grant", GRANT, 2'b00);
    cyc(); #1;
    chk("t2_grant0", GRANT, 2'b01);
    chk("t2_araddr0", {S_ARVALID, S_ARADDR}, {1'b1, 32'h408});
    s_arready = 1'b1; #1;
    chk("t2_arready0", M_ARREADY, 2'b01);
    cyc();
    m_arvalid = 2'b10; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_0000;
    sb.push_back(64'h1111_0000); #1;
    chk("t2_rvalid0", {M_RVALID, S_RREADY, S_ARVALID}, {2'b01, 1'b1, 1'b0});
    chk_sb("t2_rdata0", M_RDATA[31:0]);
    chk("t2_rdata0_other", M_RDATA[63:32], 64'h0);
    cyc(); s_rvalid = 1'b0; #1;
    chk("t2_idle_gap", GRANT, 2'b00);
    cyc(); #1;
    chk("t2_grant1", {GRANT, S_ARADDR}, {2'b10, 32'h408});
    s_arready = 1'b1;
    cyc();
    m_arvalid = 2'b00; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h2222_0001;
    sb.push_back(64'h2222_0001); #1;
    chk("t2_rvalid1", M_RVALID, 2'b10);
    chk_sb("t2_rdata1", M_RDATA[63:32]);
    chk("t2_rdata1_other", M_RDATA[31:0], 64'h0);
    cyc(); s_rvalid = 1'b0; #1;
    chk("t2_grant_clear", GRANT, 2'b00);

    // ---- T3: slave takes W two cycles before AW
    hs_aw0 = aw_hs; hs_w0 = w_hs;
    cyc();
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b11; m_rready = 2'b00;
    m_awaddr = 64'h404; m_wdata = 64'h55; #1;
    cyc(); #1;
    chk("t3_grant", GRANT, 2'b01);
    s_wready = 1'b1; #1;
    chk("t3_ready", {M_AWREADY, M_WREADY}, 4'b0001);
    cyc();
    m_wvalid = 2'b00; s_wready = 1'b0; #1;
    chk("t3_w_done", {S_AWVALID, S_WVALID}, 2'b10);
    cyc();
    s_awready = 1'b1;
    cyc();
    m_awvalid = 2'b00; s_awready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b01; #1;
    chk("t3_b_route", {M_BVALID, M_BRESP}, {2'b01, 4'b0001});
    cyc(); s_bvalid = 1'b0; s_bresp = 2'b00; #1;
    chk("t3_hs_count", {aw_hs - hs_aw0, w_hs - hs_w0}, {32'd1, 32'd1});
    chk("t3_grant_clear", GRANT, 2'b00);

    // ---- T4: master1 waits while master0's B is delayed 20 cycles
    cyc();
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
    m_awaddr = 64'h40C; m_wdata = 64'h77; #1;
    cyc(); #1;
    chk("t4_grant0", GRANT, 2'b01);
    m_arvalid = 2'b10; m_araddr = {32'h420, 32'h0}; m_rready = 2'b10;
    s_awready = 1'b1; s_wready = 1'b1;
    cyc();
    m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t4_hold", {GRANT, M_ARREADY[1], M_RVALID[1], M_BVALID, M_AWREADY[1], M_WREADY[1]}, 8'b01_0_0_00_0_0);
      cyc();
    end
    s_bvalid = 1'b1; #1;
    chk("t4_b0", M_BVALID, 2'b01);
    cyc(); s_bvalid = 1'b0; #1;
    chk("t4_idle_gap", GRANT, 2'b00);
    cyc(); #1;
    chk("t4_grant1", {GRANT, S_ARADDR}, {2'b10, 32'h420});
    s_arready = 1'b1;
    cyc();
    m_arvalid = 2'b00; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h3333;
    sb.push_back(64'h3333); #1;
    chk_sb("t4_rdata1", M_RDATA[63:32]);
    cyc(); s_rvalid = 1'b0; #1;
    chk("t4_grant_clear", GRANT, 2'b00);

    // ---- T5: reset asserted in READ after AR, then normal read
    cyc();
    m_arvalid = 2'b01; m_araddr = 64'h410; m_rready = 2'b01; #1;
    cyc(); #1;
    chk("t5_grant", GRANT, 2'b01);
    s_arready = 1'b1;
    cyc();
    m_arvalid = 2'b00; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h999; #1;
    chk("t5_rvalid_pre", M_RVALID, 2'b01);
    RST = 1'b0; #1;
    chk("t5_async_rst", {GRANT, BUSY, M_RVALID, S_RREADY, S_ARVALID}, 7'b0);
    chk("t5_async_rdata", M_RDATA, 64'h0);
    s_rvalid = 1'b0; s_rdata = '0;
    cyc(); cyc();
    RST = 1'b1;
    cyc();
    m_arvalid = 2'b01; m_araddr = 64'h410; #1;
    cyc(); #1;
    chk("t5_regrant", {GRANT, S_ARADDR}, {2'b01, 32'h410});
    s_arready = 1'b1;
    cyc();
    m_arvalid = 2'b00; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE; s_rresp = 2'b00;
    sb.push_back(64'hCAFE); #1;
    chk_sb("t5_rdata", M_RDATA[31:0]);
    cyc(); s_rvalid = 1'b0; #1;
    chk("t5_grant_clear", GRANT, 2'b00);

`ifdef ARB_TIMEOUT_EN
    // ---- T6: slave never returns B, watchdog answers after 16 cycles
    cyc();
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b00;
    m_awaddr = 64'h500; m_wdata = 64'h1; #1;
    cyc(); #1;
    chk("t6_grant", GRANT, 2'b01);
    s_awready = 1'b1; s_wready = 1'b1;
    cyc();
    m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
    repeat (14) cyc();
    #1;
    chk("t6_no_b_yet", M_BVALID, 2'b00);
    cyc(); #1;
    chk("t6_slverr", {M_BVALID, M_BRESP[1:0]}, {2'b01, 2'b10});
    chk("t6_s_quiet", {S_AWVALID, S_WVALID, S_BREADY}, 3'b000);
    m_bready = 2'b01;
    cyc(); #1;
    chk("t6_idle", {GRANT, BUSY}, 3'b000);
    m_bready = 2'b00;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_arbiter.md
Name: axi_lite_master_arbiter

Overview:
- Shares one AXI4-Lite slave-side port between `masters` requesters (picorv32 core, SPI-AXI master) in front of the peripheral interconnect (DAC, ADC, GPIO, SPI slave, program memory).
- Round-robin arbitration, one transaction in flight at a time.
- The grant is held from the address handshake through the B or R response, so responses are never mis-routed.

Parameters:
- masters, 2, number of requesting AXI4-Lite masters (2..8).
- sword, 32, address and data width.
- timeout, 1024, cycle budget per transaction (used only with ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY  in  masters each  per-master valid/ready, bit i = master i.
- M_AWADDR, M_ARADDR, M_WDATA  in  masters*sword each  flattened, slice [i*sword +: sword] = master i.
- M_WSTRB  in  masters*sword/8  flattened write strobes.
- M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID  out  masters each  per-master ready/valid.
- M_BRESP, M_RRESP  out  2*masters each  flattened responses.
- M_RDATA  out  masters*sword  flattened read data.
- S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY  out  1 each  to shared slave.
- S_AWADDR, S_ARADDR, S_WDATA  out  sword each.
- S_WSTRB  out  sword/8.
- S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID  in  1 each.
- S_BRESP, S_RRESP  in  2 each.
- S_RDATA  in  sword.
- GRANT  out  masters  one-hot current owner, 0 when idle.
- BUSY  out  1  high while in WRITE or READ.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; GRANT=0; BUSY=0; all S_* valid/ready=0; all M_* ready/valid=0; M_BRESP, M_RRESP and M_RDATA =0; last-grant pointer = masters-1, so master 0 wins first.
- Reset asserted mid-transaction: outputs drop to the reset values immediately. The in-flight transaction is abandoned; the slave must also be reset.
- Request: req[i] = (M_AWVALID[i] & M_WVALID[i]) | M_ARVALID[i].
- Arbitration, IDLE only:
  - Scan req starting at pointer+1, modulo masters.
  - First hit is registered into GRANT; the state becomes WRITE if that master has AW&W valid, otherwise READ. Write beats read within the same master.
  - One cycle of arbitration latency: a request seen in cycle n is forwarded to S_* in cycle n+1.
- WRITE:
  - S_AWADDR, S_WDATA and S_WSTRB mux from the granted master.
  - S_AWVALID = M_AWVALID[g] & ~aw_done; S_WVALID = M_WVALID[g] & ~w_done.
  - M_AWREADY[g] = S_AWREADY & ~aw_done, same pattern for W.
  - aw_done and w_done set independently on their handshakes; AW and W may complete in either order or in the same cycle.
  - After both are done, pass S_BVALID/S_BRESP to master g and M_BREADY[g] to S_BREADY.
  - On the B handshake: pointer = g, GRANT=0, state IDLE, flags cleared.
- READ:
  - S_ARVALID = M_ARVALID[g] & ~ar_done.
  - After the AR handshake, pass S_RVALID/S_RDATA/S_RRESP to master g and M_RREADY[g] to S_RREADY.
  - On the R handshake: pointer = g, state IDLE.
- Non-granted masters see all ready/valid = 0 and data = 0. In IDLE all S_* valids are 0.
- Granted master drops VALID before its handshake: AXI violation. The arbiter keeps waiting, with no deadlock recovery unless ARB_TIMEOUT_EN.
- Back-to-back: at least one IDLE cycle always separates two transactions. A single requester re-requesting every time gets 100% of grants minus those idle cycles.
- Fairness: with all masters requesting continuously, the grant sequence is 0,1,..,masters-1,0,...

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears at grant and increments each WRITE/READ cycle.
  - On reaching `timeout`, the arbiter completes toward the master:
    - Forces M_AWREADY/M_WREADY/M_ARREADY for whatever is pending.
    - Drives M_BVALID or M_RVALID with RESP=2'b10 (SLVERR) and RDATA=0 until the master accepts.
    - Deasserts all S_* valids and returns to IDLE.
- Undefined: no counter; the arbiter waits indefinitely.

Test Plan:
- Reset, then master0 writes addr 0x400 data 0xABC → S_AWADDR=0x400 and S_WDATA=0xABC one cycle after request; M_BVALID[0] with OKAY; GRANT 01→00.
- Both masters assert ARVALID (0x408) in the same cycle → master0 granted first, master1 second; each M_RDATA equals the slave data returned in its own R beat.
- Slave accepts W two cycles before AW → exactly one S_WVALID and one S_AWVALID handshake; B is routed only to the owner.
- Master1 requests while master0 waits on a slave with BVALID delayed 20 cycles → GRANT stays 01 throughout; master1 sees zero ready/valid; master1 is granted after B.
- RST pulled low in READ after AR → all outputs 0 asynchronously; after release, master0 reads 0x410 normally.
- With ARB_TIMEOUT_EN, timeout=16, slave never raises BVALID → M_BVALID asserts 16 cycles after grant with BRESP=2'b10; arbiter returns to IDLE.
